shooter_sprite_renderer: RTL
============================

# shooter_sprite_renderer

Reads the 16×16 shooter bitmap row by row from the shooter sprite ROM and serialises it into a per-pixel `pixel_on` stream for the VGA colour mux. It also holds the shooter's horizontal position, updating it once per frame from the left/right buttons. It sits between the VGA timing generator and the shooter ROM. It drives the ROM's 4-bit row index and consumes the ROM's 16-bit row word, which arrives combinationally in the same cycle.

## Interface
Parameters:
- `SPRITE_Y`, 440: top scanline of the shooter.
- `STEP`, 2: pixels moved per frame while a button is held.
- `H_ACTIVE`, 640: visible width, used for clamping.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `hpos`  in  10  current pixel column from VGA timing.
- `vpos`  in  10  current scanline from VGA timing.
- `frame_tick`  in  1  one-cycle pulse per frame, asserted during vertical blank.
- `btn_left`  in  1  move-left request, already synchronised.
- `btn_right`  in  1  move-right request, already synchronised.
- `rom_row_index`  out  4  row select to the shooter ROM; combinational.
- `rom_row_data`  in  16  ROM row word; bit 15 is the leftmost pixel.
- `pixel_on`  out  1  registered shooter pixel, corresponding to `hpos` of the previous cycle.
- `shooter_x`  out  10  registered left edge of the shooter.

## Operation
- **Line-active condition:** `line_act` = (`vpos` ≥ `SPRITE_Y`) and (`vpos` < `SPRITE_Y` + H), where H = 16 (32 with scaling).
- **ROM row index:** `rom_row_index` = (`vpos` − `SPRITE_Y`)[3:0]. With scaling it is bits [4:1] of that difference. The value is don't-care when the line is not active.
- **FSM states:** IDLE and SHIFT.
  - IDLE → SHIFT when `line_act` and `hpos` == `shooter_x`. On this transition:
    - load the 16-bit shift register from `rom_row_data`;
    - set `pixel_on` = `rom_row_data[15]`;
    - clear the bit counter.
  - In SHIFT, each cycle `pixel_on` takes the next MSB, and the counter advances.
  - After 16 bits have been output (32 with scaling), `pixel_on` ← 0 and the FSM returns to IDLE.
  - In IDLE, `pixel_on` = 0.
- **Position update:** applied only on a `frame_tick` cycle.
  - Left only: `shooter_x` ← max(0, `shooter_x` − `STEP`).
  - Right only: `shooter_x` ← min(X_MAX, `shooter_x` + `STEP`), where X_MAX = `H_ACTIVE` − W and W = 16 (32 with scaling).
  - Both pressed, or neither: no change.
  - The arithmetic is 11 bits wide, so no wrap-around is possible.
- **Clamping:** a step that would cross a bound lands exactly on the bound.
- **Movement during a row:** a `frame_tick` arriving while in SHIFT updates `shooter_x`, but the row already in flight finishes from the latched word.
- **Trigger uniqueness:** `hpos` == `shooter_x` occurs once per line, so at most one row is emitted per scanline.

## Timing
- **Reset values:** `shooter_x` = (`H_ACTIVE` − W)/2, i.e. 312 (304 with scaling); `pixel_on` = 0; FSM in IDLE; shift register and counter = 0.
- **Reset mid-row:** `pixel_on` drops to 0 immediately, without waiting for a clock edge.
- **Pixel latency:** 1 cycle. For `hpos` = `shooter_x` + k, `pixel_on` is valid in the next cycle, for k = 0..W−1. The top level delays its colour and blanking signals by one cycle to match.
- **Position latency:** `shooter_x` changes on the clock edge that samples `frame_tick`. The new position is visible from the next frame's sprite lines.
- **Buttons:** sampled only in the `frame_tick` cycle. There is no edge detection; holding a button moves `STEP` per frame.
- **Right edge:** with `shooter_x` = X_MAX, the last sprite pixel is column 639. Emission completes before horizontal blank.

## Configuration
- `SHOOTER_SCALE2_EN` defined: 2× scaling in both directions.
  - The sprite is 32×32.
  - Each bit is held for 2 cycles, so the counter counts 32 cycles.
  - The row index uses (`vpos` − `SPRITE_Y`) >> 1.
  - W = H = 32, and X_MAX = 608.
- Undefined: 1× scaling, a 16×16 sprite, W = H = 16, and X_MAX = 624.

## Structure
- **Shared package:** `SPRITE_W` = 16, `SPRITE_H` = 16, `H_ACTIVE` = 640, `V_ACTIVE` = 480, and the FSM state encoding (IDLE = 0, SHIFT = 1).
- **Sub-module `shooter_pos_ctrl`:** holds the position register, the step and clamp logic, and the reset-centring. Its ports are `clk`, `reset`, `frame_tick`, `btn_left`, `btn_right`, and `shooter_x`.
- **Top of this block:** holds the line decode, the FSM, the shift register, and the counter. The shooter ROM is instantiated by the parent, not here.

## Test plan
- **Reset:** assert `reset` mid-row → `pixel_on` = 0 immediately and `shooter_x` = 312. After release, the first `frame_tick` with no buttons pressed leaves `shooter_x` = 312.
- **Row serialisation:** ROM row 7 = 0xFFFF, `vpos` = 447, `shooter_x` = 312 → `pixel_on` = 1 for exactly 16 cycles, following `hpos` = 312..327, and 0 elsewhere on the line. On `vpos` = 440 (row 0 = 0x0180), `pixel_on` is high only for `hpos` 319 and 320.
- **Movement:** 3 frames with `btn_right` held → `shooter_x` = 318. Then one frame with both buttons held → still 318.
- **Clamp at left:** `shooter_x` = 1, press `btn_left` for one frame → `shooter_x` = 0. Press again → `shooter_x` stays 0.
- **Clamp at right:** `shooter_x` = 623, press `btn_right` → `shooter_x` = 624. At that position, a sprite row ends at `hpos` 639 and `pixel_on` = 0 at `hpos` 640.
- **Scaled mode:** with `SHOOTER_SCALE2_EN` defined, row word 0x8000 on `vpos` = 440 and 441 → `pixel_on` = 1 for 2 cycles following `hpos` = `shooter_x` and `shooter_x` + 1, then 0 for 30 cycles. After reset, `shooter_x` = 304.

Source files
------------

// File: rtl/shooter_sprite_renderer_pkg.sv
// -----------------------------------------------------------------------------
// shooter_sprite_renderer_pkg
// Shared constants, sprite geometry and FSM state encoding for the shooter
// sprite renderer and its position controller.
//
// Build option: define SHOOTER_SCALE2_EN for 2x scaling in both directions.
// The sprite is then 32x32, each ROM bit is held for two pixels, and each ROM
// row is shown on two scanlines. When the macro is undefined the sprite is
// drawn 1:1 as 16x16.
// -----------------------------------------------------------------------------
package shooter_sprite_renderer_pkg;

    localparam int unsigned SPRITE_W = 32'd16;
    localparam int unsigned SPRITE_H = 32'd16;
    localparam int unsigned H_ACTIVE = 32'd640;
    localparam int unsigned V_ACTIVE = 32'd480;

`ifdef SHOOTER_SCALE2_EN
    localparam int unsigned ROW_SHIFT = 32'd1;
`else
    localparam int unsigned ROW_SHIFT = 32'd0;
`endif

    // On-screen footprint of the sprite after scaling
    localparam int unsigned EFF_W = SPRITE_W << ROW_SHIFT;
    localparam int unsigned EFF_H = SPRITE_H << ROW_SHIFT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shooter_state_e;

    // Map a sprite-relative scanline offset onto a ROM row (each row repeats
    // on 2^ROW_SHIFT scanlines)
    function automatic logic [3:0] row_select(input logic [9:0] row_off);
        return 4'(row_off >> ROW_SHIFT);
    endfunction

endpackage

// File: rtl/shooter_pos_ctrl.sv
// -----------------------------------------------------------------------------
// shooter_pos_ctrl
// Holds the shooter's horizontal position. The position starts centred and
// moves by STEP once per frame while exactly one button is held. A step that
// would cross an edge lands on that edge.
//
// Build option: SHOOTER_SCALE2_EN widens the sprite to 32 pixels. This moves
// the right bound and the reset centre.
//
// Ports:
//   clk        in   pixel clock
//   reset      in   asynchronous active-high reset
//   frame_tick in   one-cycle pulse per frame; buttons are sampled here only
//   btn_left   in   move-left request (synchronised)
//   btn_right  in   move-right request (synchronised)
//   shooter_x  out  registered left edge of the shooter [9:0]
// -----------------------------------------------------------------------------
module shooter_pos_ctrl #(
    parameter int unsigned STEP     = 32'd2,
    parameter int unsigned H_ACTIVE = 32'd640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] shooter_x
);
    import shooter_sprite_renderer_pkg::*;

    // The arithmetic is one bit wider than the position, so a step cannot wrap.
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - EFF_W);
    localparam logic [10:0] X_RESET = 11'((H_ACTIVE - EFF_W) / 32'd2);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    logic [10:0] x_ext_s;
    logic [10:0] sum_s;
    logic [9:0]  x_nxt_s;

    assign x_ext_s = {1'b0, shooter_x};

    // Next position: step and clamp on a frame tick with exactly one button held
    always_comb begin
        sum_s   = x_ext_s + STEP_W;
        x_nxt_s = shooter_x;
        if (frame_tick && btn_left && !btn_right) begin
            if (x_ext_s < STEP_W) begin
                x_nxt_s = 10'd0;
            end else begin
                x_nxt_s = 10'(x_ext_s - STEP_W);
            end
        end else if (frame_tick && btn_right && !btn_left) begin
            if (sum_s > X_MAX) begin
                x_nxt_s = X_MAX[9:0];
            end else begin
                x_nxt_s = sum_s[9:0];
            end
        end else begin
            x_nxt_s = shooter_x;
        end
    end

    // Position register, centred on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shooter_x <= X_RESET[9:0];
        end else begin
            shooter_x <= x_nxt_s;
        end
    end

endmodule

// File: rtl/shooter_sprite_renderer.sv
// -----------------------------------------------------------------------------
// shooter_sprite_renderer
// Serialises the shooter bitmap into a per-pixel pixel_on stream. On each
// sprite scanline the row word is latched when hpos reaches shooter_x. The
// word is then emitted MSB first, one bit per pixel, or one bit per two
// pixels when scaled. pixel_on lags hpos by one cycle.
//
// Build option: define SHOOTER_SCALE2_EN for 2x scaling (32x32 on screen).
// When undefined the sprite is drawn 16x16.
//
// Ports:
//   clk           in   pixel clock
//   reset         in   asynchronous active-high reset
//   hpos, vpos    in   current pixel column / scanline [9:0]
//   frame_tick    in   once-per-frame pulse (vertical blank)
//   btn_left      in   move-left request
//   btn_right     in   move-right request
//   rom_row_index out  combinational ROM row select [3:0]
//   rom_row_data  in   ROM row word, bit 15 = leftmost pixel [15:0]
//   pixel_on      out  registered shooter pixel for the previous hpos
//   shooter_x     out  registered left edge of the shooter [9:0]
// -----------------------------------------------------------------------------
module shooter_sprite_renderer #(
    parameter int unsigned SPRITE_Y = 32'd440,
    parameter int unsigned STEP     = 32'd2,
    parameter int unsigned H_ACTIVE = 32'd640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [3:0]  rom_row_index,
    input  logic [15:0] rom_row_data,
    output logic        pixel_on,
    output logic [9:0]  shooter_x
);
    import shooter_sprite_renderer_pkg::*;

    localparam logic [4:0] LAST_CNT = 5'(EFF_W - 32'd1);

    shooter_state_e state_r, state_nxt_s;
    logic [15:0]    row_r, row_nxt_s;
    logic [4:0]     cnt_r, cnt_nxt_s;
    logic           pixel_nxt_s;
    logic           line_act_s;
    logic [4:0]     cnt_inc_s;
    logic [3:0]     bit_pos_s;

    shooter_pos_ctrl #(
        .STEP     (STEP),
        .H_ACTIVE (H_ACTIVE)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .shooter_x  (shooter_x)
    );

    assign line_act_s    = ({1'b0, vpos} >= 11'(SPRITE_Y)) &&
                           ({1'b0, vpos} <  11'(SPRITE_Y + EFF_H));
    assign rom_row_index = row_select(vpos - 10'(SPRITE_Y));

    // cnt_inc_s is the pixel offset of the bit due next. In scaled mode each
    // bit covers two offsets, so the offset is halved to select the bit.
    assign cnt_inc_s = cnt_r + 5'd1;
    assign bit_pos_s = 4'd15 - 4'(cnt_inc_s >> ROW_SHIFT);

    // Next state: trigger on the sprite's left edge, then stream the latched row
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        cnt_nxt_s   = cnt_r;
        pixel_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (line_act_s && (hpos == shooter_x)) begin
                    state_nxt_s = ST_SHIFT;
                    row_nxt_s   = rom_row_data;
                    pixel_nxt_s = rom_row_data[15];
                    cnt_nxt_s   = 5'd0;
                end else begin
                    pixel_nxt_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_IDLE;
                    pixel_nxt_s = 1'b0;
                end else begin
                    pixel_nxt_s = row_r[bit_pos_s];
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pixel_nxt_s = 1'b0;
            end
        endcase
    end

    // State, latched row word, bit counter and output pixel registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            row_r    <= 16'd0;
            cnt_r    <= 5'd0;
            pixel_on <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            row_r    <= row_nxt_s;
            cnt_r    <= cnt_nxt_s;
            pixel_on <= pixel_nxt_s;
        end
    end

endmodule
